axis_block_accumulator: RTL and testbench
=========================================

// Module: axis_block_accumulator
// PURPOSE
//  AXI-Stream sink stage placed directly downstream of an AXIS FIFO or latched connection.
//  It sums consecutive input samples into blocks of BLOCK_SIZE, or fewer when input_last ends a block early.
//  For each block it emits one word holding the sum and the sample count.
//  It feeds block statistics (e.g. mean computation) in the compression datapath.
// PARAMETERS
//  DATA_WIDTH   16  input sample width, unsigned
//  BLOCK_SIZE   16  samples per full block, >= 1
//  ACC_WIDTH    20  sum width; must be >= DATA_WIDTH + clog2(BLOCK_SIZE)
//  CNT_WIDTH    5   count width; must be >= clog2(BLOCK_SIZE+1)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-high
//  input_valid   in   1           AXIS valid from upstream FIFO
//  input_ready   out  1           AXIS ready to upstream FIFO
//  input_data    in   DATA_WIDTH  sample
//  input_last    in   1           sample closes the current block early
//  output_valid  out  1           block result valid
//  output_ready  in   1           downstream ready
//  output_data   out  ACC_WIDTH   block sum (zero-extended adds)
//  output_count  out  CNT_WIDTH   samples in block, 1..BLOCK_SIZE
// BEHAVIOUR
//  Reset (rst=1, async)
//   - state=ACCUMULATE; acc=0; cnt=0.
//   - output_valid=0, output_data=0, output_count=0, input_ready=0.
//   - input_ready is held 0 while rst=1 and rises the first cycle after rst=0.
//   - Reset mid-block discards the partial sum silently.
//  States
//   - ACCUMULATE: input_ready=1, output_valid=0.
//   - OUTPUT: output_valid=1; output_data/output_count stay stable until handshake.
//  Transfers: input xfer = input_valid & input_ready; output xfer = output_valid & output_ready.
//  ACCUMULATE, on input xfer:
//   - acc <= acc + input_data; cnt <= cnt + 1.
//   - If cnt+1 == BLOCK_SIZE or input_last=1, latch sum/count into output regs, go to OUTPUT.
//   - Next cycle: acc=0, cnt=0, output_valid=1.
//  OUTPUT:
//   - input_ready = output_ready (pass-through, no bubble).
//   - Output xfer without input xfer -> ACCUMULATE.
//   - Output xfer with input xfer -> sample is the first of the next block:
//     acc=input_data, cnt=1. Block completes immediately (BLOCK_SIZE==1 or input_last=1)
//     -> latch (input_data,1), stay in OUTPUT; else -> ACCUMULATE.
//  Latency and throughput
//   - 1 cycle from the closing input xfer to output_valid.
//   - Sustained throughput: 1 sample/cycle when output_ready=1.
//  Arithmetic: unsigned, never overflows given the ACC_WIDTH rule. No saturation logic.
//  Boundary cases
//   - input_last on the BLOCK_SIZE-th sample: one block, count=BLOCK_SIZE, no empty block.
//   - input_valid=0 while accumulating: state held, no timeout.
//   - output_valid never drops without an output xfer (AXIS rule).
// TESTING
//  1. BLOCK_SIZE=4, samples 1,2,3,4, output_ready=1 -> one word: data=10, count=4,
//     valid 1 cycle after sample 4.
//  2. Samples 5,6 then 7 with input_last=1 -> data=18, count=3; next block starts with cnt=0.
//  3. output_ready=0 for 10 cycles after a block completes -> output_valid/data/count held,
//     input_ready=0, no samples lost; release -> next block sums correctly.
//  4. Continuous input_valid=1, output_ready=1, ramp 0..15, BLOCK_SIZE=4 -> sums 6,22,38,54;
//     input_ready never 0 after reset.
//  5. Assert rst after 2 of 4 samples (values 100,100), then feed 1,1,1,1 -> output 4, not 204;
//     all outputs 0 during rst.
//  6. All inputs 0xFFFF, BLOCK_SIZE=16, ACC_WIDTH=20 -> data=0xFFFF0, count=16.

Source files
------------

// File: rtl/axis_block_accumulator.sv
// AXI-Stream block accumulator: sums up to BLOCK_SIZE unsigned samples (or fewer when
// input_last closes a block early) and emits one {sum, count} word per block.
module axis_block_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 16,
    parameter int ACC_WIDTH  = 20,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  input_last,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [ACC_WIDTH-1:0]  output_data,
    output logic [CNT_WIDTH-1:0]  output_count
);

    typedef enum logic {
        ST_ACCUMULATE = 1'b0,
        ST_OUTPUT     = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] BLOCK_CNT = CNT_WIDTH'(BLOCK_SIZE);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [ACC_WIDTH-1:0]   out_data_q;
    logic [CNT_WIDTH-1:0]   out_count_q;
    logic                   ready_en_q;

    logic [ACC_WIDTH-1:0]   acc_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   block_done;

    // ready_en_q keeps input_ready low during reset and releases it one cycle later.
    assign input_ready  = ready_en_q & ((state_q == ST_ACCUMULATE) | output_ready);
    assign output_valid = (state_q == ST_OUTPUT);
    assign output_data  = out_data_q;
    assign output_count = out_count_q;

    assign in_xfer  = input_valid & input_ready;
    assign out_xfer = output_valid & output_ready;

    // acc_q/cnt_q are cleared on entering ST_OUTPUT, so the same sum/count and
    // completion test also serve a sample that opens the next block from ST_OUTPUT.
    always_comb begin
        acc_d      = acc_q + ACC_WIDTH'(input_data);
        cnt_d      = cnt_q + ONE_CNT;
        block_done = (cnt_d == BLOCK_CNT) || input_last;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUMULATE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (in_xfer) begin
                if (block_done) begin
                    out_data_q  <= acc_d;
                    out_count_q <= cnt_d;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    state_q     <= ST_OUTPUT;
                end else begin
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    state_q <= ST_ACCUMULATE;
                end
            end else if (out_xfer) begin
                state_q <= ST_ACCUMULATE;
            end
        end
    end

endmodule

// File: tb/tb_axis_block_accumulator.sv
// Directed testbench for axis_block_accumulator: a BLOCK_SIZE=4 instance for the
// protocol scenarios and a BLOCK_SIZE=16 instance for the full-scale sum.
module tb_axis_block_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_data;
    logic [4:0]  out_count;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [15:0] w_in_data = '0;
    logic        w_in_last = 1'b0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [19:0] w_out_data;
    logic [4:0]  w_out_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axis_block_accumulator #(
        .DATA_WIDTH(16), .BLOCK_SIZE(4), .ACC_WIDTH(20), .CNT_WIDTH(5)
    ) dut4 (
        .clk(clk), .rst(rst),
        .input_valid(in_valid), .input_ready(in_ready),
        .input_data(in_data), .input_last(in_last),
        .output_valid(out_valid), .output_ready(out_ready),
        .output_data(out_data), .output_count(out_count)
    );

    axis_block_accumulator #(
        .DATA_WIDTH(16), .BLOCK_SIZE(16), .ACC_WIDTH(20), .CNT_WIDTH(5)
    ) dut16 (
        .clk(clk), .rst(rst),
        .input_valid(w_in_valid), .input_ready(w_in_ready),
        .input_data(w_in_data), .input_last(w_in_last),
        .output_valid(w_out_valid), .output_ready(w_out_ready),
        .output_data(w_out_data), .output_count(w_out_count)
    );

    // Advance one clock; observations are taken 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({in_ready, out_valid, out_data, out_count} !== '0)
            $display("FAIL reset_outputs: ready=%0b valid=%0b data=%0d count=%0d, want all 0",
                     in_ready, out_valid, out_data, out_count);
        else n_pass++;
        step();
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_ready_low: ready=%0b, want 0", in_ready);
        else n_pass++;
        step();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_ready_rise: ready=%0b valid=%0b, want 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_full_block();
        out_ready = 1'b1;
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL full_early_valid: valid=%0b, want 0", out_valid);
        else n_pass++;
        send(16'd4, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd10 || out_count !== 5'd4)
            $display("FAIL full_block: valid=%0b data=%0d count=%0d, want 1/10/4",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL full_drop: valid=%0b, want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_early_last();
        send(16'd5, 1'b0);
        send(16'd6, 1'b0);
        send(16'd7, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd18 || out_count !== 5'd3)
            $display("FAIL early_last: valid=%0b data=%0d count=%0d, want 1/18/3",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
        // A fresh block after an early close must count from zero again.
        for (int i = 0; i < 4; i++) send(16'd1, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd4 || out_count !== 5'd4)
            $display("FAIL after_last: valid=%0b data=%0d count=%0d, want 1/4/4",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
    endtask

    task automatic test_last_boundary();
        // input_last on the BLOCK_SIZE-th sample yields exactly one block.
        send(16'd2, 1'b0);
        send(16'd2, 1'b0);
        send(16'd2, 1'b0);
        send(16'd2, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd8 || out_count !== 5'd4)
            $display("FAIL last_on_full: valid=%0b data=%0d count=%0d, want 1/8/4",
                     out_valid, out_data, out_count);
        else n_pass++;
        // A one-sample block accepted while the previous result is handed off.
        send(16'd7, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd7 || out_count !== 5'd1)
            $display("FAIL single_in_output: valid=%0b data=%0d count=%0d, want 1/7/1",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL no_empty_block: valid=%0b, want 0", out_valid);
        else n_pass++;
        // Idle input must hold the partial block indefinitely.
        send(16'd3, 1'b0);
        for (int i = 0; i < 5; i++) step();
        send(16'd3, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd6 || out_count !== 5'd2)
            $display("FAIL idle_hold: valid=%0b data=%0d count=%0d, want 1/6/2",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
    endtask

    task automatic test_stall();
        int bad = 0;
        out_ready = 1'b0;
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd9;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 20'd10 || out_count !== 5'd4 || in_ready !== 1'b0)
                bad++;
            step();
        end
        n_total++;
        if (bad != 0) $display("FAIL stall_hold: %0d bad cycles, want 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL stall_release: valid=%0b, want 0", out_valid);
        else n_pass++;
        send(16'd9, 1'b0);
        send(16'd9, 1'b0);
        send(16'd9, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd36 || out_count !== 5'd4)
            $display("FAIL stall_next: valid=%0b data=%0d count=%0d, want 1/36/4",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [19:0] got[$];
        logic [19:0] exp_sums[4] = '{20'd6, 20'd22, 20'd38, 20'd54};
        int          not_ready = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'(i);
            if (in_ready !== 1'b1) not_ready++;
            step();
            if (out_valid === 1'b1) got.push_back(out_data);
        end
        in_valid = 1'b0;
        n_total++;
        if (not_ready != 0) $display("FAIL b2b_ready: %0d stalled cycles, want 0", not_ready);
        else n_pass++;
        n_total++;
        if (got.size() != 4) $display("FAIL b2b_count: %0d words, want 4", got.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= got.size() || got[i] !== exp_sums[i])
                $display("FAIL b2b_sum%0d: got %0d want %0d", i,
                         (i < got.size()) ? got[i] : 20'd0, exp_sums[i]);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_reset_mid_block();
        send(16'd100, 1'b0);
        send(16'd100, 1'b0);
        rst = 1'b1;
        #1;
        n_total++;
        if ({in_ready, out_valid, out_data, out_count} !== '0 || w_in_ready !== 1'b0)
            $display("FAIL midreset_outputs: ready=%0b valid=%0b data=%0d count=%0d, want all 0",
                     in_ready, out_valid, out_data, out_count);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 20'd4 || out_count !== 5'd4)
            $display("FAIL midreset_sum: valid=%0b data=%0d count=%0d, want 1/4/4",
                     out_valid, out_data, out_count);
        else n_pass++;
        drain();
    endtask

    task automatic test_max_sum();
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_data   = 16'hFFFF;
        for (int i = 0; i < 15; i++) step();
        n_total++;
        if (w_out_valid !== 1'b0) $display("FAIL max_early_valid: valid=%0b, want 0", w_out_valid);
        else n_pass++;
        step();
        w_in_valid = 1'b0;
        n_total++;
        if (w_out_valid !== 1'b1 || w_out_data !== 20'hFFFF0 || w_out_count !== 5'd16)
            $display("FAIL max_sum: valid=%0b data=%h count=%0d, want 1/ffff0/16",
                     w_out_valid, w_out_data, w_out_count);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_early_last();
        test_last_boundary();
        test_stall();
        test_back_to_back();
        test_reset_mid_block();
        test_max_sum();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
